hdd_stepper_synth: RTL and testbench

//  Multi-track tone synthesizer that drives 4-phase stepper coils so they "sing".
//  A host loads one packet over a write-only SPI-style link (cs/sck/sdi).

---
 rtl/hdd_stepper_synth.sv | 137 +++++++++++++
 tb/tb_hdd_stepper_synth.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdd_stepper_synth.sv
// hdd_stepper_synth: multi-track tone synthesizer that drives 4-phase stepper coils.
// A host loads one packet per track over a write-only serial link (cs/sck/sdi).
// When a complete frame closes, the packet is committed to the per-track step generators.
module hdd_stepper_synth #(
  parameter int unsigned NUM_TRACKS  = 1,
  parameter int unsigned PACKET_SIZE = 24,
  parameter int unsigned CLK_DIV     = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sck,
  input  logic                  sdi,
  output logic [NUM_TRACKS-1:0] A,
  output logic [NUM_TRACKS-1:0] B,
  output logic [NUM_TRACKS-1:0] C,
  output logic [NUM_TRACKS-1:0] D
);

  localparam int unsigned TOTAL_BITS = PACKET_SIZE * NUM_TRACKS;
  localparam int unsigned BCNT_W     = $clog2(TOTAL_BITS + 1);
  localparam int unsigned CNT_W      = 16 + $clog2(CLK_DIV);

  logic [TOTAL_BITS-1:0] shreg;
  logic [BCNT_W-1:0]     bit_cnt;
  logic                  frame_full;

  logic cs_meta, cs_sync, cs_prev, armed;
  logic commit_c;

  logic [NUM_TRACKS-1:0][PACKET_SIZE-1:0] pkt;
  logic [NUM_TRACKS-1:0][15:0]            period_q, period_d;
  logic [NUM_TRACKS-1:0]                  en_q, en_d, dir_q, dir_d;
  logic [NUM_TRACKS-1:0][1:0]             phase_q, phase_d;
  logic [NUM_TRACKS-1:0][CNT_W-1:0]       cnt_q, cnt_d, term_c;
  logic [NUM_TRACKS-1:0]                  a_d, b_d, c_d, d_d;
  logic                                   unused_reserved;

  // Serial shifter: MSB first, newest bit enters at the LSB, oldest bits fall off the top.
  always_ff @(posedge sck) begin
    if (cs) shreg <= {shreg[TOTAL_BITS-2:0], sdi};
  end

  // Saturating bit counter, held clear whenever the frame is deselected.
  always_ff @(posedge sck or negedge cs) begin
    if (!cs) bit_cnt <= '0;
    else if (bit_cnt != BCNT_W'(TOTAL_BITS)) bit_cnt <= bit_cnt + BCNT_W'(1);
  end

  // Latch frame completeness on the closing cs edge, before the counter is cleared.
  always_ff @(negedge cs) begin
    frame_full <= (bit_cnt == BCNT_W'(TOTAL_BITS));
  end

  // cs synchronizer and frame arming; reset forces the chain idle-high so a frame in flight is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
      armed   <= 1'b0;
    end else begin
      cs_meta <= cs;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
      if (cs_sync && !cs_prev)      armed <= 1'b1;
      else if (!cs_sync && cs_prev) armed <= 1'b0;
    end
  end

  assign commit_c = armed & cs_prev & ~cs_sync & frame_full;

  // Track 0 occupies the most significant packet of the shifter.
  assign pkt = shreg;

  // Per-track next state: commit wins over a step boundary; outputs follow the next phase.
  always_comb begin
    period_d        = period_q;
    en_d            = en_q;
    dir_d           = dir_q;
    phase_d         = phase_q;
    cnt_d           = cnt_q;
    term_c          = '0;
    a_d             = '0;
    b_d             = '0;
    c_d             = '0;
    d_d             = '0;
    unused_reserved = 1'b0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      term_c[t]       = CNT_W'(period_q[t]) * CNT_W'(CLK_DIV) - CNT_W'(1);
      unused_reserved = unused_reserved ^ (^pkt[NUM_TRACKS-1-t][6:1]);
      if (commit_c) begin
        period_d[t] = pkt[NUM_TRACKS-1-t][23:8];
        en_d[t]     = pkt[NUM_TRACKS-1-t][7];
        dir_d[t]    = pkt[NUM_TRACKS-1-t][0];
        cnt_d[t]    = '0;
      end else if (en_q[t] && (period_q[t] != 16'd0)) begin
        if (cnt_q[t] == term_c[t]) begin
          cnt_d[t]   = '0;
          phase_d[t] = dir_q[t] ? (phase_q[t] + 2'd1) : (phase_q[t] - 2'd1);
        end else begin
          cnt_d[t] = cnt_q[t] + CNT_W'(1);
        end
      end
      a_d[t] = en_d[t] && (phase_d[t] == 2'd0);
      b_d[t] = en_d[t] && (phase_d[t] == 2'd1);
      c_d[t] = en_d[t] && (phase_d[t] == 2'd2);
      d_d[t] = en_d[t] && (phase_d[t] == 2'd3);
    end
  end

  // Track registers and one-hot coil drive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      period_q <= '0;
      en_q     <= '0;
      dir_q    <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
      A        <= '0;
      B        <= '0;
      C        <= '0;
      D        <= '0;
    end else begin
      period_q <= period_d;
      en_q     <= en_d;
      dir_q    <= dir_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      A        <= a_d;
      B        <= b_d;
      C        <= c_d;
      D        <= d_d;
    end
  end

endmodule

// File: tb/tb_hdd_stepper_synth.sv
// Bench for hdd_stepper_synth: three instances (1 track div 1, 2 tracks div 1, 1 track div 3)
// checked every cycle against an arithmetic phase model, plus directed interval checks.
module tb_hdd_stepper_synth;

  logic clk = 1'b0;
  logic reset, cs1, cs2, sck, sdi;
  logic [0:0] a1, b1, c1, d1, a3, b3, c3, d3;
  logic [1:0] a2, b2, c2, d2;

  always #5 clk = ~clk;

  hdd_stepper_synth #(.NUM_TRACKS(1), .PACKET_SIZE(24), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .cs(cs1), .sck(sck), .sdi(sdi),
    .A(a1), .B(b1), .C(c1), .D(d1));
  hdd_stepper_synth #(.NUM_TRACKS(2), .PACKET_SIZE(24), .CLK_DIV(1)) u_dut2 (
    .clk(clk), .reset(reset), .cs(cs2), .sck(sck), .sdi(sdi),
    .A(a2), .B(b2), .C(c2), .D(d2));
  hdd_stepper_synth #(.NUM_TRACKS(1), .PACKET_SIZE(24), .CLK_DIV(3)) u_dut3 (
    .clk(clk), .reset(reset), .cs(cs1), .sck(sck), .sdi(sdi),
    .A(a3), .B(b3), .C(c3), .D(d3));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  // Model tracks: 0 = dut1, 1/2 = dut2 track 0/1, 3 = dut3. Groups: 0 = cs1 frames, 1 = cs2 frames.
  int         m_period[4];
  bit         m_en[4];
  bit         m_dir[4];
  int         m_base[4];
  int         m_k[4];
  int         pend[2];
  bit         frame_ok[2];
  logic [63:0] sh[2];
  logic [63:0] snap[2];
  bit         cnow[2];
  logic [63:0] mp;

  function automatic int grp(input int m);  return (m == 1 || m == 2) ? 1 : 0; endfunction
  function automatic int ntr(input int g);  return (g == 1) ? 2 : 1;          endfunction
  function automatic int tidx(input int m); return (m == 2) ? 1 : 0;          endfunction
  function automatic int cdiv(input int m); return (m == 3) ? 3 : 1;          endfunction

  // Phase = base advanced by one per full step interval elapsed since the last commit.
  function automatic int phase_of(input int m);
    if (m_en[m] && m_period[m] != 0)
      return (m_base[m] + (m_dir[m] ? 1 : 3) * (m_k[m] / (m_period[m] * cdiv(m)))) % 4;
    return m_base[m];
  endfunction

  function automatic logic [3:0] exp_out(input int m);
    if (!m_en[m]) return 4'b0000;
    return 4'b1000 >> phase_of(m);
  endfunction

  function automatic logic [3:0] dut_out(input int m);
    case (m)
      0:       return {a1[0], b1[0], c1[0], d1[0]};
      1:       return {a2[0], b2[0], c2[0], d2[0]};
      2:       return {a2[1], b2[1], c2[1], d2[1]};
      default: return {a3[0], b3[0], c3[0], d3[0]};
    endcase
  endfunction

  // Model update on each clock edge; a committed frame lands on the third edge after cs drops.
  always @(posedge clk) begin
    if (reset !== 1'b1) begin
      for (int m = 0; m < 4; m++) begin
        m_period[m] = 0; m_en[m] = 0; m_dir[m] = 0; m_base[m] = 0; m_k[m] = 0;
      end
      pend[0] = 0;
      pend[1] = 0;
      if (cs1) frame_ok[0] = 1'b0;
      if (cs2) frame_ok[1] = 1'b0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        cnow[g] = (pend[g] == 1);
        if (pend[g] > 0) pend[g] = pend[g] - 1;
      end
      for (int m = 0; m < 4; m++) begin
        if (cnow[grp(m)]) begin
          mp          = snap[grp(m)] >> (24 * (ntr(grp(m)) - 1 - tidx(m)));
          m_base[m]   = phase_of(m);
          m_period[m] = int'(mp[23:8]);
          m_en[m]     = mp[7];
          m_dir[m]    = mp[0];
          m_k[m]      = 0;
        end else begin
          m_k[m] = m_k[m] + 1;
        end
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int m = 0; m < 4; m++) begin
        n_checks++;
        if (dut_out(m) !== exp_out(m)) begin
          n_err++;
          $display("FAIL cyc_cmp track=%0d t=%0t got=%b exp=%b", m, $time, dut_out(m), exp_out(m));
        end
      end
    end
  end

  task automatic check_lit(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_max(input string name, input int got, input int lim);
    n_checks++;
    if (got > lim) begin
      n_err++;
      $display("FAIL %s got=%0d exp<=%0d", name, got, lim);
    end
  endtask

  // Count negedges until a track shows pattern pat; a blown budget is a failure.
  task automatic wait_out(input int m, input logic [3:0] pat, input int budget, output int cyc);
    cyc = 0;
    while (dut_out(m) !== pat && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (dut_out(m) !== pat) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_timeout track=%0d got=%b exp=%b", m, dut_out(m), pat);
    end
  endtask

  // Shift nbits of data MSB first; optional reset pulse before bit rst_at; cs drops on a negedge.
  task automatic send_frame(input int g, input logic [63:0] data, input int nbits, input int rst_at);
    if (g == 0) cs1 = 1'b1; else cs2 = 1'b1;
    frame_ok[g] = 1'b1;
    #7;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i == rst_at) begin
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #3;
      end
      sdi   = data[i];
      sh[g] = {sh[g][62:0], data[i]};
      #3 sck = 1'b1;
      #3 sck = 1'b0;
    end
    #4;
    @(negedge clk);
    if (g == 0) cs1 = 1'b0; else cs2 = 1'b0;
    snap[g] = sh[g];
    pend[g] = (frame_ok[g] && nbits >= 24 * ntr(g)) ? 3 : 0;
  endtask

  int cyc, g, n, nbits, rst_at, mode;
  logic [63:0] d;
  logic [15:0] per;
  logic        en_b, dir_b;
  logic [5:0]  rsv;

  initial begin
    reset = 1'b0; cs1 = 1'b0; cs2 = 1'b0; sck = 1'b0; sdi = 1'b0;
    sh[0] = '0; sh[1] = '0; snap[0] = '0; snap[1] = '0;
    pend[0] = 0; pend[1] = 0; frame_ok[0] = 0; frame_ok[1] = 0;

    // Reset and idle
    repeat (2) @(negedge clk);
    for (int m = 0; m < 4; m++) check_lit("reset_zero", int'(dut_out(m)), 0);
    chk_on = 1'b1;
    reset  = 1'b1;
    repeat (10) @(negedge clk);
    check_lit("idle_zero", int'(dut_out(0)), 0);
    check_lit("idle_zero2", int'({dut_out(1), dut_out(2)}), 0);

    // Forward at 276 clk/step
    send_frame(0, 64'h0114FF, 24, -1);
    wait_out(0, 4'b1000, 6, cyc);   check_max("commit_lat", cyc, 4);
    wait_out(0, 4'b0100, 400, cyc); check_lit("step_ab", cyc, 276);
    wait_out(0, 4'b0010, 400, cyc); check_lit("step_bc", cyc, 276);
    wait_out(0, 4'b0001, 400, cyc); check_lit("step_cd", cyc, 276);
    wait_out(0, 4'b1000, 400, cyc); check_lit("step_da", cyc, 276);

    // Fast forward, then reverse
    send_frame(0, 64'h000481, 24, -1);
    repeat (4) @(negedge clk);
    wait_out(0, 4'b0100, 20, cyc);
    wait_out(0, 4'b0010, 20, cyc);  check_lit("fwd4_bc", cyc, 4);
    wait_out(0, 4'b0001, 20, cyc);  check_lit("fwd4_cd", cyc, 4);
    send_frame(0, 64'h000480, 24, -1);
    repeat (4) @(negedge clk);
    wait_out(0, 4'b0010, 20, cyc);
    wait_out(0, 4'b0100, 20, cyc);
    wait_out(0, 4'b1000, 20, cyc);  check_lit("rev4_ba", cyc, 4);
    wait_out(0, 4'b0001, 20, cyc);  check_lit("rev4_ad", cyc, 4);
    wait_out(0, 4'b0010, 20, cyc);  check_lit("rev4_dc", cyc, 4);

    // Disable freezes the phase, re-enable resumes there
    send_frame(0, 64'h0114FF, 24, -1);
    repeat (4) @(negedge clk);
    wait_out(0, 4'b1000, 1200, cyc);
    wait_out(0, 4'b0100, 400, cyc);
    send_frame(0, 64'h01147F, 24, -1);
    wait_out(0, 4'b0000, 6, cyc);   check_max("disable_lat", cyc, 4);
    repeat (20) @(negedge clk);
    check_lit("disabled_zero", int'(dut_out(0)), 0);
    send_frame(0, 64'h0114FF, 24, -1);
    wait_out(0, 4'b0100, 6, cyc);   check_max("resume_phase", cyc, 4);

    // Short frame ignored, reset mid-frame discards the frame
    send_frame(0, 64'h2AA, 10, -1);
    wait_out(0, 4'b0010, 400, cyc);
    wait_out(0, 4'b0001, 400, cyc); check_lit("short_ignored", cyc, 276);
    send_frame(0, 64'h000481, 24, 12);
    repeat (6) @(negedge clk);
    check_lit("rst_midframe", int'(dut_out(0)), 0);
    check_lit("rst_midframe3", int'(dut_out(3)), 0);

    // Two independent tracks
    send_frame(1, 64'h0114FF0217FF, 48, -1);
    wait_out(1, 4'b1000, 6, cyc);   check_max("t0_commit", cyc, 4);
    check_lit("t1_commit", int'(dut_out(2)), 8);
    wait_out(1, 4'b0100, 600, cyc); check_lit("t0_period", cyc, 276);
    wait_out(2, 4'b0100, 600, cyc); check_lit("t1_first", cyc, 259);
    wait_out(2, 4'b0010, 600, cyc); check_lit("t1_period", cyc, 535);

    // Randomized frames: short, exact and over-long, occasional resets
    for (int it = 0; it < 40; it++) begin
      g = $urandom_range(0, 1);
      n = ntr(g);
      d = '0;
      for (int t = 0; t < n; t++) begin
        per   = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
        en_b  = ($urandom_range(0, 3) != 0);
        dir_b = 1'($urandom_range(0, 1));
        rsv   = 6'($urandom_range(0, 63));
        d     = (d << 24) | 64'({per, en_b, rsv, dir_b});
      end
      mode  = $urandom_range(0, 5);
      nbits = 24 * n;
      if (mode == 0) begin
        nbits = $urandom_range(1, 24 * n - 1);
      end else if (mode == 1) begin
        nbits = 24 * n + $urandom_range(1, 6);
        d     = d | (64'($urandom) << (24 * n));
      end
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, nbits - 1) : -1;
      send_frame(g, d, nbits, rst_at);
      repeat ($urandom_range(5, 60)) @(negedge clk);
      if ($urandom_range(0, 12) == 0) begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
      end
    end

    repeat (10) @(negedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
